// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with make/break/extended scan-code decoding into a held-key vector.
// Optional PS2_GLITCH_FILTER_EN adds a FILTER_LEN-sample stability filter on the synced ps2_clk.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned BIT_W = $clog2(11);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_lvl;
  logic             clk_prev;
  logic             fall;
  logic             data_s;
  logic [BIT_W-1:0] bit_cnt;
  logic [8:0]       shreg;
  logic [TO_W-1:0]  to_cnt;
  dec_state_t       state, state_n;
  logic [3:0]       keys_n;
  logic [2:0]       slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign data_s = data_sync[1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int unsigned FL_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  logic            clk_filt;
  logic [FL_W-1:0] flt_cnt;

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FL_W'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) clk_prev <= 1'b1;
    else     clk_prev <= clk_lvl;
  end

  assign fall = clk_prev & ~clk_lvl;

  // shreg collects d0..d7 then parity, LSB first; the stop bit is judged live on the 11th edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == '0) begin
          if (!data_s) bit_cnt <= BIT_W'(1);
        end else if (bit_cnt == BIT_W'(10)) begin
          bit_cnt <= '0;
          if ((^shreg) && data_s) begin
            byte_data  <= shreg[7:0];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shreg   <= {data_s, shreg[8:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt == '0) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        bit_cnt   <= '0;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Returns {hit, index}; the E0 flag is part of the key identity.
  function automatic logic [2:0] key_slot(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h174:  return 3'b100;
      9'h16B:  return 3'b101;
      9'h012:  return 3'b110;
      9'h02D:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      keys  <= '0;
    end else begin
      state <= state_n;
      keys  <= keys_n;
    end
  end

  always_comb begin
    state_n = state;
    keys_n  = keys;
    slot    = '0;
    if (frame_err) begin
      state_n = IDLE;
    end else if (byte_valid) begin
      unique case (state)
        IDLE: begin
          if (byte_data == 8'hF0)      state_n = BRK;
          else if (byte_data == 8'hE0) state_n = EXT;
          else begin
            slot = key_slot(1'b0, byte_data);
            if (slot[2]) keys_n[slot[1:0]] = 1'b1;
          end
        end
        EXT: begin
          if (byte_data == 8'hF0)      state_n = EXT_BRK;
          else if (byte_data == 8'hE0) state_n = EXT;
          else begin
            slot = key_slot(1'b1, byte_data);
            if (slot[2]) keys_n[slot[1:0]] = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          if (byte_data == 8'hE0) state_n = EXT_BRK;
          else begin
            slot = key_slot(1'b0, byte_data);
            if (slot[2]) keys_n[slot[1:0]] = 1'b0;
            state_n = IDLE;
          end
        end
        EXT_BRK: begin
          slot = key_slot(1'b1, byte_data);
          if (slot[2]) keys_n[slot[1:0]] = 1'b0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: prefix-flag model plus directed PS/2 frames.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int unsigned TO = 250;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keys;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keys       (keys),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // 500 kHz system clock keeps a 60 us PS/2 bit at 30 clk cycles.
  always #1000 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] b;
  } exp_t;

  exp_t        expq[$];
  int unsigned passed     = 0;
  int unsigned total      = 0;
  int unsigned err_pulses = 0;
  logic [3:0]  m_keys = '0;
  logic [7:0]  m_byte = '0;
  bit          m_ext  = 1'b0;
  bit          m_brk  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int key_of(input bit ext, input logic [7:0] code);
    if (ext && code == 8'h74)  return 0;
    if (ext && code == 8'h6B)  return 1;
    if (!ext && code == 8'h12) return 2;
    if (!ext && code == 8'h2D) return 3;
    return -1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   k;
    check("keys", keys, m_keys);
    check("valid_err_exclusive", byte_valid & frame_err, 0);
    if (frame_err) err_pulses++;
    if (byte_valid || frame_err) begin
      if (expq.size() == 0) begin
        check("unexpected_pulse", {byte_valid, frame_err}, 0);
      end else begin
        e = expq.pop_front();
        check("pulse_kind", {byte_valid, frame_err}, e.err ? 2'b01 : 2'b10);
        if (e.err) begin
          m_ext = 1'b0;
          m_brk = 1'b0;
        end else begin
          m_byte = e.b;
          if (e.b == 8'hE0) m_ext = 1'b1;
          else if (e.b == 8'hF0) m_brk = 1'b1;
          else begin
            k = key_of(m_ext, e.b);
            if (k >= 0) m_keys[k] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
          end
        end
      end
    end
    check("byte_data", byte_data, m_byte);
    if (rst) begin
      m_keys = '0;
      m_byte = '0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      expq.delete();
    end
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int unsigned n, input bit glitch);
    for (int unsigned i = 0; i < n; i++) begin
      ps2_data = bits[i];
      #15000 ps2_clk = 1'b0;
      #30000 ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        #5000 ps2_clk = 1'b0;
        #6000 ps2_clk = 1'b1;
        #4000;
      end else begin
        #15000;
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(posedge clk);
    check(name, expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0,
                           input bit glitch = 1'b0);
    exp_t e;
    e.err = bad_par | bad_stop;
    e.b   = b;
    expq.push_back(e);
    send_bits(frame_of(b, bad_par, bad_stop), 11, glitch);
    #100000;
    drain("drain");
  endtask

  initial begin
    #50ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    exp_t        te;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_keys", keys, 4'b0000);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_byte_data", byte_data, 8'h00);

    send_byte(8'hE0); send_byte(8'h74);
    check("t1_make_right", keys, 4'b0001);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    check("t1_break_right", keys, 4'b0000);

    send_byte(8'h12); send_byte(8'h2D);
    check("t2_jump_restart", keys, 4'b1100);
    send_byte(8'hF0); send_byte(8'h12);
    check("t2_break_jump", keys, 4'b1000);
    check("t2_byte_data", byte_data, 8'h12);

    e0 = err_pulses;
    send_byte(8'h1C, 1'b1);
    check("t3_parity_err_count", err_pulses - e0, 1);
    check("t3_byte_data_kept", byte_data, 8'h12);
    send_byte(8'hE0); send_byte(8'h6B);
    check("t3_make_left", keys, 4'b1010);

    send_byte(8'hF0); send_byte(8'h2D);
    check("t4_break_restart", keys, 4'b0010);
    e0 = err_pulses;
    te.err = 1'b1;
    te.b   = 8'h00;
    expq.push_back(te);
    send_bits(frame_of(8'h2D, 1'b0, 1'b0), 5, 1'b0);
    #700000;
    drain("t4_timeout_drain");
    check("t4_timeout_count", err_pulses - e0, 1);
    send_byte(8'h2D);
    check("t4_after_timeout", keys, 4'b1010);

    e0 = err_pulses;
    send_byte(8'hE0); send_byte(8'h74, 1'b0, 1'b1);
    check("t5_stop_err_count", err_pulses - e0, 1);
    send_byte(8'h74);
    check("t5_nonext_74", keys, 4'b1010);

    send_bits(frame_of(8'hE0, 1'b0, 1'b0), 6, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("t6_rst_keys", keys, 4'b0000);
    check("t6_rst_byte_data", byte_data, 8'h00);
    check("t6_rst_pulses", {byte_valid, frame_err}, 0);
    send_byte(8'hE0); send_byte(8'h74);
    check("t6_make_right", keys, 4'b0001);

`ifdef PS2_GLITCH_FILTER_EN
    send_byte(8'hE0, 1'b0, 1'b0, 1'b1); send_byte(8'h6B, 1'b0, 1'b0, 1'b1);
    check("glitch_make_left", keys, 4'b0011);
    check("glitch_byte_data", byte_data, 8'h6B);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
